pkt_framer: RTL

- Per-virtual-channel packet boundary tracker on the chiplet flit stream.
- Decodes each header flit, computes the packet's total flit count and counts flits through to the CRC flit.
- Tags each forwarded flit with start/end-of-packet, flit index and packet length; flags malformed headers.
- Optionally drops comma packets.
- Sits between the PHY receive path and the switch input buffers; successor to the single-stream expected-length decode, generalised to N interleaved VCs.

---
 rtl/pkt_framer_pkg.sv | 83 ++++++++
 rtl/pkt_framer_if.sv | 36 +++
 rtl/pkt_framer_vc_tracker.sv | 69 ++++++
 rtl/pkt_framer.sv | 81 ++++++++
 4 files changed

// File: rtl/pkt_framer_pkg.sv
// Shared types, defaults and the header length decode for the packet framer.
package pkt_framer_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned META_W             = 4;
  localparam int unsigned LONG_MAX_DATA_DEF  = 128;
  localparam int unsigned SHORT_MAX_DATA_DEF = 16;
  localparam int unsigned PKT_MAX_LENGTH_DEF = 131;
  localparam int unsigned PKT_LEN_W          = $clog2(PKT_MAX_LENGTH_DEF);

  typedef logic [WORD_W-1:0]    chiplet_word_t;
  typedef logic [PKT_LEN_W-1:0] pkt_len_t;

  typedef struct packed {
    logic [META_W-1:0] meta;
    chiplet_word_t     data;
  } flit_t;

  // Header format lives in word[31:28]; anything not listed is malformed.
  typedef enum logic [3:0] {
    FMT_LONG_RD  = 4'h0,
    FMT_LONG_WR  = 4'h1,
    FMT_MEM_RESP = 4'h2,
    FMT_MSG      = 4'h3,
    FMT_SW_CFG   = 4'h4,
    FMT_SHORT_RD = 4'h8,
    FMT_SHORT_WR = 4'h9,
    FMT_COMMA    = 4'hA
  } hdr_fmt_e;

  typedef struct packed {
    pkt_len_t len;
    logic     err;
    logic     comma;
  } hdr_info_t;

  typedef struct packed {
    logic     sop;
    logic     eop;
    logic     err;
    logic     drop;
    pkt_len_t idx;
    pkt_len_t len;
  } tag_t;

  // Malformed or oversize headers report err with a 1-flit length.
  function automatic hdr_info_t hdr_pkt_len(input chiplet_word_t w,
                                            input int unsigned long_max,
                                            input int unsigned short_max,
                                            input int unsigned pkt_max);
    hdr_info_t   res;
    int unsigned l;
    int unsigned s;
    int unsigned n;
    logic        err;
    logic        comma;
    l     = (w[6:0] == 7'd0) ? long_max : 32'(w[6:0]);
    s     = (w[3:0] == 4'd0) ? short_max : 32'(w[3:0]);
    n     = 0;
    err   = 1'b0;
    comma = 1'b0;
    case (w[31:28])
      FMT_LONG_RD:  n = 3;
      FMT_LONG_WR:  n = 3 + l;
      FMT_MEM_RESP: n = 2 + l;
      FMT_MSG:      n = 2 + l;
      FMT_SW_CFG:   n = 1;
      FMT_SHORT_RD: n = 2;
      FMT_SHORT_WR: n = 2 + s;
      FMT_COMMA: begin
        n     = 1;
        comma = 1'b1;
      end
      default:      err = 1'b1;
    endcase
    if (!err && (n > pkt_max)) err = 1'b1;
    res.err   = err;
    res.comma = comma && !err;
    res.len   = err ? PKT_LEN_W'(1) : PKT_LEN_W'(n);
    return res;
  endfunction

endpackage

// File: rtl/pkt_framer_if.sv
// Input and output flit streams of the packet framer plus its status.
interface pkt_framer_if
  import pkt_framer_pkg::*;
#(
  parameter int unsigned NUM_VC = 2
);
  localparam int unsigned VC_W = $clog2(NUM_VC);

  logic              in_valid;
  logic              in_ready;
  logic [VC_W-1:0]   in_vc;
  flit_t             in_flit;
  logic              out_valid;
  logic              out_ready;
  logic [VC_W-1:0]   out_vc;
  flit_t             out_flit;
  logic              out_sop;
  logic              out_eop;
  pkt_len_t          out_idx;
  pkt_len_t          out_len;
  logic              out_err;
  logic [7:0]        err_count;
  logic [NUM_VC-1:0] vc_busy;

  modport slave (
    input  in_valid, in_vc, in_flit, out_ready,
    output in_ready, out_valid, out_vc, out_flit, out_sop, out_eop,
           out_idx, out_len, out_err, err_count, vc_busy
  );

  modport master (
    output in_valid, in_vc, in_flit, out_ready,
    input  in_ready, out_valid, out_vc, out_flit, out_sop, out_eop,
           out_idx, out_len, out_err, err_count, vc_busy
  );
endinterface

// File: rtl/pkt_framer_vc_tracker.sv
// Single-VC packet boundary tracker: header/body FSM plus flit counter.
module pkt_vc_tracker
  import pkt_framer_pkg::*;
#(
  parameter bit DROP_COMMA = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_en,
  input  hdr_info_t i_hdr,
  output tag_t      o_tag_c,
  output logic      o_busy
);
  typedef enum logic {ST_IDLE, ST_BODY} state_e;

  state_e   r_state;
  pkt_len_t r_cnt;
  pkt_len_t r_len;
  logic     r_busy;

  // Tag for a flit arriving now on this VC.
  always_comb begin
    o_tag_c = '0;
    if (r_state == ST_IDLE) begin
      o_tag_c.sop  = 1'b1;
      o_tag_c.len  = i_hdr.len;
      o_tag_c.eop  = (i_hdr.len == PKT_LEN_W'(1));
      o_tag_c.err  = i_hdr.err;
      o_tag_c.drop = DROP_COMMA && i_hdr.comma;
    end else begin
      o_tag_c.idx = r_cnt;
      o_tag_c.len = r_len;
      o_tag_c.eop = (r_cnt == (r_len - PKT_LEN_W'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_busy  <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!i_hdr.err && (i_hdr.len > PKT_LEN_W'(1))) begin
            r_state <= ST_BODY;
            r_cnt   <= PKT_LEN_W'(1);
            r_len   <= i_hdr.len;
            r_busy  <= 1'b1;
          end
        end
        ST_BODY: begin
          if (o_tag_c.eop) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + PKT_LEN_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/pkt_framer.sv
// Per-VC packet framer: one output register stage tagging each forwarded flit.
module pkt_framer
  import pkt_framer_pkg::*;
#(
  parameter int unsigned NUM_VC         = 2,
  parameter int unsigned LONG_MAX_DATA  = LONG_MAX_DATA_DEF,
  parameter int unsigned SHORT_MAX_DATA = SHORT_MAX_DATA_DEF,
  parameter int unsigned PKT_MAX_LENGTH = PKT_MAX_LENGTH_DEF,
  parameter bit          DROP_COMMA     = 1'b1
) (
  input logic        clk,
  input logic        rst,
  pkt_framer_if.slave bus
);
  localparam int unsigned VC_W = $clog2(NUM_VC);

  logic              w_accept;
  hdr_info_t         w_hdr;
  tag_t              w_tag [NUM_VC];
  tag_t              w_sel;
  logic [NUM_VC-1:0] w_busy;

  logic              r_out_valid;
  logic [VC_W-1:0]   r_out_vc;
  flit_t             r_out_flit;
  tag_t              r_out_tag;
  logic [7:0]        r_err_count;

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_hdr        = hdr_pkt_len(bus.in_flit.data, LONG_MAX_DATA,
                                    SHORT_MAX_DATA, PKT_MAX_LENGTH);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    pkt_vc_tracker #(.DROP_COMMA(DROP_COMMA)) u_trk (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_accept && (bus.in_vc == VC_W'(v))),
      .i_hdr   (w_hdr),
      .o_tag_c (w_tag[v]),
      .o_busy  (w_busy[v])
    );
  end

  assign w_sel = w_tag[bus.in_vc];

  // Output register: load on an accepted non-dropped flit, else drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_vc    <= '0;
      r_out_flit  <= '0;
      r_out_tag   <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept && !w_sel.drop) begin
        r_out_valid <= 1'b1;
        r_out_vc    <= bus.in_vc;
        r_out_flit  <= bus.in_flit;
        r_out_tag   <= w_sel;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && w_sel.err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_vc    = r_out_vc;
  assign bus.out_flit  = r_out_flit;
  assign bus.out_sop   = r_out_tag.sop;
  assign bus.out_eop   = r_out_tag.eop;
  assign bus.out_idx   = r_out_tag.idx;
  assign bus.out_len   = r_out_tag.len;
  assign bus.out_err   = r_out_tag.err;
  assign bus.err_count = r_err_count;
  assign bus.vc_busy   = w_busy;

endmodule
